// File: rtl/spi_pkg.sv
// Shared definitions for the SPI packet master: FSM state encodings, the SPI
// mode constants and the default timing values.
package spi_pkg;

    // Per-byte frame sequencing used by the byte engine.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } spi_state_e;

    // Packet-level sequencing in the top: idle, fetching bytes, sending a TX
    // byte, publishing the packet.
    typedef enum logic [1:0] {
        PKT_IDLE = 2'd0,
        PKT_XFER = 2'd1,
        PKT_TX   = 2'd2,
        PKT_DONE = 2'd3
    } pkt_state_e;

    // SPI mode 0: SCK idles low, data sampled on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int DEF_PKT_BYTES = 3;
    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_CS_LEAD   = 4;
    localparam int DEF_CS_GAP    = 8;

    // Width of the shared timing counter; all timing parameters must fit.
    localparam int CNT_W = 8;

endpackage

// File: rtl/spi_pkt_master_if.sv
// SPI bus between the packet master (companion FPGA) and the transceiver's
// SPI slave. CS is active-low, SCK idles low.
interface spi_pkt_master_if;
    logic SCK;
    logic CS;
    logic MOSI;
    logic MISO;

    modport master (output SCK, output CS, output MOSI, input MISO);
    modport slave  (input SCK, input CS, input MOSI, output MISO);
endinterface

// File: rtl/spi_byte_engine.sv
// One-byte SPI frame: CS lead, 8 mode-0 bit times MSB first, CS trail, CS gap.
// done is a combinational strobe on the last gap cycle so the caller can chain
// the next frame through start with no idle cycle in between.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CS_LEAD = DEF_CS_LEAD,
    parameter int CS_GAP  = DEF_CS_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       sck,
    output logic       cs_n,
    output logic       mosi
);

    localparam logic [CNT_W-1:0] LEAD_TC = CNT_W'(CS_LEAD - 1);
    localparam logic [CNT_W-1:0] DIV_TC  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(CS_GAP - 1);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [6:0]       tx_sr_q, tx_sr_d;   // bits still to be driven after the current one
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             done_s;

    // Next-state and output computation for one byte frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        done_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEAD;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    tx_sr_d = tx_byte[6:0];
                    mosi_d  = tx_byte[7];
                end else begin
                    cs_n_d = 1'b1;
                    sck_d  = SPI_CPOL;
                    mosi_d = 1'b0;
                end
            end
            ST_LEAD: begin
                if (cnt_q == LEAD_TC) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    bit_cnt_d = 4'd0;
                    sck_d     = SPI_CPOL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_TC) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (sck_q == SPI_CPOL) begin
                        // Rising edge: capture MISO.
                        rx_sr_d   = {rx_sr_q[6:0], miso};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        // Falling edge: present the next MOSI bit.
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[5:0], 1'b0};
                        if (bit_cnt_q == 4'd8) begin
                            state_d = ST_TRAIL;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TRAIL: begin
                if (cnt_q == LEAD_TC) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_TC) begin
                    done_s = 1'b1;
                    cnt_d  = '0;
                    if (start) begin
                        state_d = ST_LEAD;
                        cs_n_d  = 1'b0;
                        tx_sr_d = tx_byte[6:0];
                        mosi_d  = tx_byte[7];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                cs_n_d  = 1'b1;
                sck_d   = SPI_CPOL;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // Frame state, counters and registered SPI pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 4'd0;
            rx_sr_q   <= 8'h00;
            tx_sr_q   <= 7'h00;
            sck_q     <= SPI_CPOL;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign rx_byte = rx_sr_q;
    assign done    = done_s;
    assign sck     = sck_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: rtl/spi_pkt_master.sv
// SPI packet master: on each rising edge of the transceiver's pkt_rec, fetches
// PKT_BYTES bytes, one CS frame per byte, and publishes them on pkt_data with
// a one-cycle pkt_valid. The first byte lands in the MSBs.
// Optional build macro SPI_PKT_MASTER_TX_EN adds a single-byte TX frame
// (tx_req / tx_byte / tx_done); without it MOSI stays 0.
module spi_pkt_master
    import spi_pkg::*;
#(
    parameter int PKT_BYTES = DEF_PKT_BYTES,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int CS_LEAD   = DEF_CS_LEAD,
    parameter int CS_GAP    = DEF_CS_GAP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pkt_rec,
    spi_pkt_master_if.master       bus,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   pkt_valid,
    output logic                   busy,
    output logic                   overrun
`ifdef SPI_PKT_MASTER_TX_EN
    ,
    input  logic                   tx_req,
    input  logic [7:0]             tx_byte,
    output logic                   tx_done
`endif
);

    localparam logic [7:0] LAST_BYTE = 8'(PKT_BYTES - 1);

    logic                   sync1_q, sync2_q, edge_q;
    logic                   rise_s;
    pkt_state_e             state_q, state_d;
    logic [7:0]             byte_cnt_q, byte_cnt_d;
    logic [8*PKT_BYTES-1:0] staging_q, staging_d;
    logic [8*PKT_BYTES-1:0] pkt_data_q, pkt_data_d;
    logic                   pkt_valid_q, pkt_valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
`ifdef SPI_PKT_MASTER_TX_EN
    logic                   tx_done_q, tx_done_d;
`endif

    logic                   eng_start_s;
    logic [7:0]             eng_tx_byte_s;
    logic [7:0]             eng_rx_s;
    logic                   eng_done_s;
    logic                   eng_sck_s, eng_cs_n_s, eng_mosi_s;

    // Two-flop synchroniser for pkt_rec plus the edge flop for rise detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= pkt_rec;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign rise_s = sync2_q & ~edge_q;

    // Packet FSM: trigger, byte sequencing, staging and publication.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        staging_d     = staging_q;
        pkt_data_d    = pkt_data_q;
        pkt_valid_d   = 1'b0;
        busy_d        = busy_q;
        overrun_d     = 1'b0;
        eng_start_s   = 1'b0;
        eng_tx_byte_s = 8'h00;
`ifdef SPI_PKT_MASTER_TX_EN
        tx_done_d     = 1'b0;
`endif
        case (state_q)
            PKT_IDLE: begin
                if (rise_s) begin
                    state_d     = PKT_XFER;
                    byte_cnt_d  = 8'd0;
                    busy_d      = 1'b1;
                    eng_start_s = 1'b1;
`ifdef SPI_PKT_MASTER_TX_EN
                end else if (tx_req) begin
                    state_d       = PKT_TX;
                    busy_d        = 1'b1;
                    eng_start_s   = 1'b1;
                    eng_tx_byte_s = tx_byte;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            PKT_XFER: begin
                overrun_d = rise_s;
                if (eng_done_s) begin
                    for (int i = 0; i < PKT_BYTES; i++) begin
                        staging_d[8*(PKT_BYTES-1-i) +: 8] = (byte_cnt_q == 8'(i)) ?
                            eng_rx_s : staging_q[8*(PKT_BYTES-1-i) +: 8];
                    end
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = PKT_DONE;
                    end else begin
                        byte_cnt_d  = byte_cnt_q + 8'd1;
                        eng_start_s = 1'b1;
                    end
                end else begin
                    state_d = PKT_XFER;
                end
            end
`ifdef SPI_PKT_MASTER_TX_EN
            PKT_TX: begin
                // MISO is shifted in by the engine but never stored here.
                overrun_d = rise_s;
                if (eng_done_s) begin
                    tx_done_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = PKT_IDLE;
                end else begin
                    state_d = PKT_TX;
                end
            end
`endif
            PKT_DONE: begin
                // A rise landing here is not counted as overrun; it is picked
                // up from IDLE only if the edge flop has not yet caught up.
                pkt_data_d  = staging_q;
                pkt_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = PKT_IDLE;
            end
            default: begin
                state_d = PKT_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Packet state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PKT_IDLE;
            byte_cnt_q  <= 8'd0;
            staging_q   <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SPI_PKT_MASTER_TX_EN
            tx_done_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            staging_q   <= staging_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
`ifdef SPI_PKT_MASTER_TX_EN
            tx_done_q   <= tx_done_d;
`endif
        end
    end

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV),
        .CS_LEAD (CS_LEAD),
        .CS_GAP  (CS_GAP)
    ) u_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (eng_start_s),
        .tx_byte (eng_tx_byte_s),
        .miso    (bus.MISO),
        .rx_byte (eng_rx_s),
        .done    (eng_done_s),
        .sck     (eng_sck_s),
        .cs_n    (eng_cs_n_s),
        .mosi    (eng_mosi_s)
    );

    assign bus.SCK   = eng_sck_s;
    assign bus.CS    = eng_cs_n_s;
    assign bus.MOSI  = eng_mosi_s;
    assign pkt_data  = pkt_data_q;
    assign pkt_valid = pkt_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
`ifdef SPI_PKT_MASTER_TX_EN
    assign tx_done   = tx_done_q;
`endif

endmodule

// File: tb/tb_spi_pkt_master.sv
// Directed bench for spi_pkt_master with CLK_DIV=2, CS_LEAD=2, CS_GAP=4,
// PKT_BYTES=3 (L=122). A mode-0 slave model answers from a 3-byte table.
// pkt_rec is driven just after a falling clock edge; the synchronised rise is
// seen after 2 rising edges, so pkt_valid is expected 2+L = 124 rising edges
// after pkt_rec goes high.
module tb_spi_pkt_master;

    localparam int PB = 3;
    localparam int CD = 2;
    localparam int CL = 2;
    localparam int CG = 4;
    localparam int EXP_LAT = 124;

    logic          clk = 1'b0;
    logic          rst;
    logic          pkt_rec;
    logic [8*PB-1:0] pkt_data;
    logic          pkt_valid, busy, overrun;
`ifdef SPI_PKT_MASTER_TX_EN
    logic          tx_req;
    logic [7:0]    tx_byte;
    logic          tx_done;
`endif

    spi_pkt_master_if bus();

    spi_pkt_master #(.PKT_BYTES(PB), .CLK_DIV(CD), .CS_LEAD(CL), .CS_GAP(CG)) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_rec   (pkt_rec),
        .bus       (bus),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SPI_PKT_MASTER_TX_EN
        ,
        .tx_req    (tx_req),
        .tx_byte   (tx_byte),
        .tx_done   (tx_done)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Slave model and bus monitor state.
    logic [7:0] resp [3];
    int         frame_base = 0;
    logic       miso_r = 1'b0;
    logic       prev_cs = 1'b1;
    logic       prev_sck = 1'b0;
    logic [7:0] cur = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    int frames = 0, bad_frames = 0, rises = 0, high_len = 0, last_gap = 0;
    int pv_cnt = 0, ov_cnt = 0, mosi_hi = 0, txd_cnt = 0;

    assign bus.MISO = miso_r;

    function automatic logic [7:0] pick(input int k);
        case (k % 3)
            0:       return resp[0];
            1:       return resp[1];
            default: return resp[2];
        endcase
    endfunction

    // Mode-0 slave: bit 7 at CS fall, next bit after each SCK fall; also
    // counts frames, SCK rises per frame, CS-high gaps and output pulses.
    always @(negedge clk) begin
        if (pkt_valid) pv_cnt <= pv_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (bus.MOSI) mosi_hi <= mosi_hi + 1;
`ifdef SPI_PKT_MASTER_TX_EN
        if (tx_done) txd_cnt <= txd_cnt + 1;
`endif
        if (bus.CS) high_len <= high_len + 1;
        if (prev_cs && !bus.CS) begin
            last_gap <= high_len;
            high_len <= 0;
            frames   <= frames + 1;
            rises    <= 0;
            cur      <= pick(frames - frame_base);
            miso_r   <= pick(frames - frame_base) >> 7;
        end
        if (!bus.CS && !prev_sck && bus.SCK) begin
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[6:0], bus.MOSI};
        end
        if (!bus.CS && prev_sck && !bus.SCK) begin
            cur    <= {cur[6:0], 1'b0};
            miso_r <= cur[6];
        end
        if (!prev_cs && bus.CS && rises != 8) bad_frames <= bad_frames + 1;
        prev_cs  <= bus.CS;
        prev_sck <= bus.SCK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise pkt_rec and wait (bounded) for pkt_valid; optionally drop and
    // re-raise pkt_rec mid-transfer. lat=-1 if pkt_valid never came.
    task automatic run_packet(input int drop_at, input int rise_at,
                              output int lat, output int busy_lo);
        lat = -1;
        busy_lo = 0;
        pkt_rec = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (k == drop_at) pkt_rec = 1'b0;
            if (k == rise_at) pkt_rec = 1'b1;
            if (pkt_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (k >= 3 && busy !== 1'b1) busy_lo++;
        end
        pkt_rec = 1'b0;
    endtask

    int lat, blo, bf, bb, bp, bo, bt;

    initial begin
        rst = 1'b1;
        pkt_rec = 1'b0;
        resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00;
`ifdef SPI_PKT_MASTER_TX_EN
        tx_req = 1'b0;
        tx_byte = 8'h00;
`endif
        tick(3);
        check("rst_sck",     64'(bus.SCK),   64'd0);
        check("rst_cs",      64'(bus.CS),    64'd1);
        check("rst_mosi",    64'(bus.MOSI),  64'd0);
        check("rst_data",    64'(pkt_data),  64'd0);
        check("rst_valid",   64'(pkt_valid), 64'd0);
        check("rst_busy",    64'(busy),      64'd0);
        check("rst_overrun", 64'(overrun),   64'd0);
        rst = 1'b0;
        tick(5);

        // Packet A5 3C 7E
        resp[0] = 8'hA5; resp[1] = 8'h3C; resp[2] = 8'h7E;
        frame_base = frames; bf = frames; bb = bad_frames; bp = pv_cnt;
        run_packet(-1, -1, lat, blo);
        check("lat_a",    64'(lat),      64'd124);
        check("data_a",   64'(pkt_data), 64'hA53C7E);
        check("busy_end", 64'(busy),     64'd0);
        check("busy_a",   64'(blo),      64'd0);
        tick(10);
        check("frames_a", 64'(frames - bf),     64'd3);
        check("sck8_a",   64'(bad_frames - bb), 64'd0);
        check("pv_a",     64'(pv_cnt - bp),     64'd1);
        check("gap_a",    64'(last_gap),        64'd4);
        check("hold_a",   64'(pkt_data),        64'hA53C7E);

        // MISO constant 1
        resp[0] = 8'hFF; resp[1] = 8'hFF; resp[2] = 8'hFF;
        frame_base = frames;
        run_packet(-1, -1, lat, blo);
        check("lat_ones",  64'(lat),      64'd124);
        check("data_ones", 64'(pkt_data), 64'hFFFFFF);
        tick(10);

        // MISO constant 0
        resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00;
        frame_base = frames;
        run_packet(-1, -1, lat, blo);
        check("data_zero", 64'(pkt_data), 64'h000000);
        check("gap_zero",  64'(last_gap), 64'd4);
        tick(10);

        // Second rise around cycle 50 of a transfer
        resp[0] = 8'h12; resp[1] = 8'h34; resp[2] = 8'h56;
        frame_base = frames; bf = frames; bp = pv_cnt; bo = ov_cnt;
        run_packet(40, 48, lat, blo);
        check("lat_ovr",    64'(lat),      64'd124);
        check("busy_ovr",   64'(blo),      64'd0);
        check("data_ovr",   64'(pkt_data), 64'h123456);
        check("ovr_pulse",  64'(ov_cnt - bo), 64'd1);
        tick(300);
        check("ovr_noq_pv", 64'(pv_cnt - bp), 64'd1);
        check("ovr_noq_fr", 64'(frames - bf), 64'd3);
        check("ovr_hold",   64'(pkt_data),    64'h123456);

        // Reset during the second byte's shift phase
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
        frame_base = frames;
        pkt_rec = 1'b1;
        tick(55);
        check("mid_cs_low", 64'(bus.CS), 64'd0);
        rst = 1'b1;
        pkt_rec = 1'b0;
        #1;
        check("abort_cs",   64'(bus.CS),  64'd1);
        check("abort_sck",  64'(bus.SCK), 64'd0);
        check("abort_busy", 64'(busy),    64'd0);
        tick(3);
        rst = 1'b0;
        bp = pv_cnt;
        tick(200);
        check("abort_pv",   64'(pv_cnt - bp), 64'd0);
        check("abort_data", 64'(pkt_data),    64'd0);
        resp[0] = 8'hDE; resp[1] = 8'hAD; resp[2] = 8'h99;
        frame_base = frames;
        run_packet(-1, -1, lat, blo);
        check("post_rst_lat",  64'(lat),      64'd124);
        check("post_rst_data", 64'(pkt_data), 64'hDEAD99);
        tick(10);

        // pkt_rec held high for 500 cycles
        resp[0] = 8'h5A; resp[1] = 8'hC3; resp[2] = 8'h0F;
        frame_base = frames; bf = frames; bp = pv_cnt;
        pkt_rec = 1'b1;
        tick(500);
        pkt_rec = 1'b0;
        tick(20);
        check("held_pv",     64'(pv_cnt - bp), 64'd1);
        check("held_frames", 64'(frames - bf), 64'd3);
        check("held_data",   64'(pkt_data),    64'h5AC30F);

`ifdef SPI_PKT_MASTER_TX_EN
        // Single TX byte
        bp = pv_cnt; bt = txd_cnt; bf = frames;
        tx_byte = 8'hC3;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        tick(60);
        check("tx_mosi",   64'(mosi_cap),     64'hC3);
        check("tx_done",   64'(txd_cnt - bt), 64'd1);
        check("tx_no_pv",  64'(pv_cnt - bp),  64'd0);
        check("tx_frames", 64'(frames - bf),  64'd1);
`else
        check("mosi_quiet", 64'(mosi_hi), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
